// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared definitions for the FFT frame controller:
//   - default frame size, word width and watchdog limit
//   - sample / bin word typedefs (signed, 5.7 and 8.4 fixed point)
//   - FSM state encoding, both as an enum and as plain 2-bit constants
//     for code that prefers legacy-style localparam states.
package fft_pkg;

    localparam int FFT_N_PTS   = 8;
    localparam int FFT_DW      = 12;
    localparam int FFT_TIMEOUT = 64;

    // Time-domain sample, 5.7 fixed point.
    typedef logic signed [FFT_DW-1:0] sample_t;
    // Frequency bin component, 8.4 fixed point.
    typedef logic signed [FFT_DW-1:0] bin_t;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_UNLOAD = 2'd3
    } fft_state_e;

    localparam logic [1:0] ST_LOAD   = S_LOAD;
    localparam logic [1:0] ST_START  = S_START;
    localparam logic [1:0] ST_WAIT   = S_WAIT;
    localparam logic [1:0] ST_UNLOAD = S_UNLOAD;

endpackage

// File: rtl/fft_watchdog.sv
// fft_watchdog
//   Cycle counter that flags when 'run' has been held for TIMEOUT cycles.
//   Only instantiated when FFT_CTRL_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   run       - count while high, clear to zero while low
//   expired   - high in the cycle where the count equals TIMEOUT-1, so the
//               consumer acting on it at the next edge lands exactly
//               TIMEOUT cycles after 'run' first rose
module fft_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = run && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (run) begin
            // Hold at the limit; the controller leaves WAIT on expiry anyway.
            cnt_d = expired ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
//   Collects N_PTS time samples into a frame, strobes an external FFT core,
//   captures the returned bins into a local buffer and streams them out.
//   FSM: LOAD -> START -> WAIT -> UNLOAD -> LOAD.
// Ports:
//   CLK, RESET                 - clock, asynchronous active-high reset
//   IN_VALID/IN_READY/IN_SAMPLE- sample input stream (accepted in LOAD only)
//   FFT_ENABLE                 - one-cycle start strobe (the START state)
//   FFT_SAMPLES[N_PTS]         - frame to the core, index 0 = first sample
//   FFT_FINISH                 - core done strobe, honoured only in WAIT
//   FFT_RE/FFT_IM[N_PTS]       - core bins, captured when FFT_FINISH is seen
//   OUT_VALID/OUT_READY        - bin output stream
//   OUT_RE/OUT_IM/OUT_INDEX    - current bin and its number
//   OUT_LAST                   - high with bin N_PTS-1
//   BUSY                       - high outside LOAD
//   ERROR                      - sticky watchdog flag
//   DBG_STATE                  - current FSM state encoding (fft_pkg ST_*)
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high; a source holds its data stable while valid is high and ready
//   is low, and ready never depends on valid.
// Configuration: define FFT_CTRL_TIMEOUT_EN to enable the WAIT watchdog.
//   Without it WAIT waits indefinitely and ERROR is tied low.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int N_PTS   = FFT_N_PTS,
    parameter int DW      = FFT_DW,
    parameter int TIMEOUT = FFT_TIMEOUT
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [DW-1:0]            IN_SAMPLE,
    output logic                     FFT_ENABLE,
    output logic [DW-1:0]            FFT_SAMPLES [N_PTS],
    input  logic                     FFT_FINISH,
    input  logic [DW-1:0]            FFT_RE [N_PTS],
    input  logic [DW-1:0]            FFT_IM [N_PTS],
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [DW-1:0]            OUT_RE,
    output logic [DW-1:0]            OUT_IM,
    output logic [$clog2(N_PTS)-1:0] OUT_INDEX,
    output logic                     OUT_LAST,
    output logic                     BUSY,
    output logic                     ERROR,
    output logic [1:0]               DBG_STATE
);

    localparam int              AW       = $clog2(N_PTS);
    localparam logic [AW-1:0]   LAST_IDX = AW'(N_PTS - 1);

    logic [1:0]    state_q,  state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [DW-1:0] samples_q [N_PTS];
    logic [DW-1:0] samples_d [N_PTS];
    logic [DW-1:0] bin_re_q  [N_PTS];
    logic [DW-1:0] bin_re_d  [N_PTS];
    logic [DW-1:0] bin_im_q  [N_PTS];
    logic [DW-1:0] bin_im_d  [N_PTS];

`ifdef FFT_CTRL_TIMEOUT_EN
    logic tmo_expired;
    logic error_q, error_d;

    // The watchdog runs from the START cycle, so its expiry lands exactly
    // TIMEOUT cycles after FFT_ENABLE.
    fft_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (CLK),
        .rst     (RESET),
        .run     ((state_q == ST_START) || (state_q == ST_WAIT)),
        .expired (tmo_expired)
    );
`endif

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        samples_d = samples_q;
        bin_re_d  = bin_re_q;
        bin_im_d  = bin_im_q;
`ifdef FFT_CTRL_TIMEOUT_EN
        error_d   = error_q;
`endif

        case (state_q)
            ST_LOAD: begin
                if (IN_VALID) begin
                    samples_d[wr_cnt_q] = IN_SAMPLE;
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        state_d  = ST_START;
                    end else begin
                        wr_cnt_d = wr_cnt_q + AW'(1);
                    end
                end
            end

            ST_START: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // A finish in the expiry cycle still wins: the result is good.
                if (FFT_FINISH) begin
                    bin_re_d = FFT_RE;
                    bin_im_d = FFT_IM;
                    rd_cnt_d = '0;
                    state_d  = ST_UNLOAD;
                end
`ifdef FFT_CTRL_TIMEOUT_EN
                else if (tmo_expired) begin
                    error_d  = 1'b1;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                    state_d  = ST_LOAD;
                end
`endif
            end

            ST_UNLOAD: begin
                if (OUT_READY) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        rd_cnt_d = '0;
                        wr_cnt_d = '0;
                        state_d  = ST_LOAD;
                    end else begin
                        rd_cnt_d = rd_cnt_q + AW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_LOAD;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            for (int i = 0; i < N_PTS; i++) begin
                samples_q[i] <= '0;
                bin_re_q[i]  <= '0;
                bin_im_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            samples_q <= samples_d;
            bin_re_q  <= bin_re_d;
            bin_im_q  <= bin_im_d;
        end
    end

`ifdef FFT_CTRL_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign ERROR = error_q;
`else
    assign ERROR = 1'b0;
`endif

    assign IN_READY    = (state_q == ST_LOAD);
    assign FFT_ENABLE  = (state_q == ST_START);
    assign BUSY        = (state_q != ST_LOAD);
    assign OUT_VALID   = (state_q == ST_UNLOAD);
    assign FFT_SAMPLES = samples_q;
    assign DBG_STATE   = state_q;

    // rd_cnt is zero outside UNLOAD, so the index is already clean there;
    // the bin words are gated so stale buffer contents never show.
    assign OUT_INDEX = rd_cnt_q;
    assign OUT_LAST  = OUT_VALID && (rd_cnt_q == LAST_IDX);
    assign OUT_RE    = OUT_VALID ? bin_re_q[rd_cnt_q] : '0;
    assign OUT_IM    = OUT_VALID ? bin_im_q[rd_cnt_q] : '0;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl
//   Directed bench for fft_frame_ctrl with a behavioural FFT core stub that
//   raises FFT_FINISH 3 cycles after FFT_ENABLE and returns bin k as
//   re = k*16, im = -k*16. Inputs are driven and outputs sampled on the
//   falling clock edge. Define FFT_CTRL_TIMEOUT_EN to build the watchdog
//   scenario instead of the indefinite-wait scenario.
module tb_fft_frame_ctrl;
    import fft_pkg::*;

    localparam int N   = 8;
    localparam int DW  = 12;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_sample = '0;
    logic          fft_enable;
    logic [DW-1:0] fft_samples [N];
    logic          fft_finish;
    logic [DW-1:0] fft_re [N];
    logic [DW-1:0] fft_im [N];
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic [2:0]    out_index;
    logic          out_last;
    logic          busy;
    logic          error;
    logic [1:0]    dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] vec1 [N] = '{12'h640, 12'hE00, 12'h800, 12'h270,
                                12'h480, 12'h730, 12'h880, 12'hE80};
    logic [DW-1:0] vec2 [N] = '{12'h001, 12'h7FF, 12'h123, 12'hFFF,
                                12'h0A5, 12'h5A0, 12'h333, 12'hC3C};
    logic [DW-1:0] vec3 [N] = '{12'h111, 12'h222, 12'h333, 12'h444,
                                12'h555, 12'h666, 12'h777, 12'h888};

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    fft_frame_ctrl #(
        .N_PTS   (N),
        .DW      (DW),
        .TIMEOUT (TMO)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .IN_VALID    (in_valid),
        .IN_READY    (in_ready),
        .IN_SAMPLE   (in_sample),
        .FFT_ENABLE  (fft_enable),
        .FFT_SAMPLES (fft_samples),
        .FFT_FINISH  (fft_finish),
        .FFT_RE      (fft_re),
        .FFT_IM      (fft_im),
        .OUT_VALID   (out_valid),
        .OUT_READY   (out_ready),
        .OUT_RE      (out_re),
        .OUT_IM      (out_im),
        .OUT_INDEX   (out_index),
        .OUT_LAST    (out_last),
        .BUSY        (busy),
        .ERROR       (error),
        .DBG_STATE   (dbg_state)
    );

    // ---------------- FFT core stub ----------------
    logic stub_en       = 1'b1;
    logic stub_finish   = 1'b0;
    logic manual_finish = 1'b0;
    assign fft_finish = stub_finish | manual_finish;

    initial begin
        for (int k = 0; k < N; k++) begin
            fft_re[k] = 12'(k * 16);
            fft_im[k] = 12'(0 - k * 16);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            stub_finish = 1'b0;
            if (stub_en && fft_enable) begin
                repeat (3) @(negedge clk);
                stub_finish = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge after the sample
    // was accepted, with in_valid still high.
    task automatic push(input logic [DW-1:0] v);
        int t = 0;
        in_valid  = 1'b1;
        in_sample = v;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL push_ready in_ready=%b exp 1 after %0d cycles", in_ready, t);
        end
        @(negedge clk);
    endtask

    task automatic wait_out_valid(input string tag);
        int t = 0;
        while (out_valid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (out_valid !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL %s_wait out_valid=%b exp 1 within 50 cycles", tag, out_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %b exp 0", busy); end
        tests_run++; if (fft_enable !== 1'b0) begin tests_failed++; $display("FAIL rst_enable got %b exp 0", fft_enable); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy_rel got %b exp 0", busy); end
        tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL rst_out_last got %b exp 0", out_last); end
        tests_run++; if (out_index !== 3'd0) begin tests_failed++; $display("FAIL rst_out_index got %0d exp 0", out_index); end
        tests_run++; if (out_re !== 12'h000) begin tests_failed++; $display("FAIL rst_out_re got %h exp 000", out_re); end
        tests_run++; if (out_im !== 12'h000) begin tests_failed++; $display("FAIL rst_out_im got %h exp 000", out_im); end
        tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL rst_error got %b exp 0", error); end
        tests_run++; if (dbg_state !== ST_LOAD) begin tests_failed++; $display("FAIL rst_state got %0d exp %0d", dbg_state, ST_LOAD); end
        for (int i = 0; i < N; i++) begin
            tests_run++; if (fft_samples[i] !== 12'h000) begin tests_failed++; $display("FAIL rst_samples[%0d] got %h exp 000", i, fft_samples[i]); end
        end
    endtask

    task automatic test_frame();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) push(vec1[i]);
        in_valid = 1'b0;
        // First cycle after the last-sample handshake.
        tests_run++; if (fft_enable !== 1'b1) begin tests_failed++; $display("FAIL frame_enable got %b exp 1", fft_enable); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL frame_in_ready got %b exp 0", in_ready); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL frame_busy got %b exp 1", busy); end
        for (int i = 0; i < N; i++) begin
            tests_run++; if (fft_samples[i] !== vec1[i]) begin tests_failed++; $display("FAIL frame_samples[%0d] got %h exp %h", i, fft_samples[i], vec1[i]); end
        end
        @(negedge clk);
        tests_run++; if (fft_enable !== 1'b0) begin tests_failed++; $display("FAIL frame_enable_pulse got %b exp 0", fft_enable); end
        tests_run++; if (dbg_state !== ST_WAIT) begin tests_failed++; $display("FAIL frame_state_wait got %0d exp %0d", dbg_state, ST_WAIT); end
        repeat (2) @(negedge clk);
        // Finish is high in this cycle; output only appears one cycle later.
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL frame_valid_early got %b exp 0", out_valid); end
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL frame_valid[%0d] got %b exp 1", k, out_valid); end
            tests_run++; if (out_index !== 3'(k)) begin tests_failed++; $display("FAIL frame_index[%0d] got %0d exp %0d", k, out_index, k); end
            tests_run++; if (out_re !== 12'(k * 16)) begin tests_failed++; $display("FAIL frame_re[%0d] got %h exp %h", k, out_re, 12'(k * 16)); end
            tests_run++; if (out_im !== 12'(0 - k * 16)) begin tests_failed++; $display("FAIL frame_im[%0d] got %h exp %h", k, out_im, 12'(0 - k * 16)); end
            tests_run++; if (out_last !== (k == N - 1)) begin tests_failed++; $display("FAIL frame_last[%0d] got %b exp %b", k, out_last, (k == N - 1)); end
            @(negedge clk);
        end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL frame_valid_end got %b exp 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL frame_ready_end got %b exp 1", in_ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL frame_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_ignore_finish();
        manual_finish = 1'b1;
        @(negedge clk);
        manual_finish = 1'b0;
        tests_run++; if (dbg_state !== ST_LOAD) begin tests_failed++; $display("FAIL ignfin_state got %0d exp %0d", dbg_state, ST_LOAD); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL ignfin_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_stall();
        int            exp_k   = 0;
        logic          stalled = 1'b0;
        logic [DW-1:0] prev_re = '0;
        logic [2:0]    prev_ix = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            push(vec2[i]);
            if (i < N - 1) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            tests_run++; if (fft_samples[i] !== vec2[i]) begin tests_failed++; $display("FAIL stall_samples[%0d] got %h exp %h", i, fft_samples[i], vec2[i]); end
        end
        for (int cyc = 0; cyc < 100 && exp_k < N; cyc++) begin
            if (out_valid === 1'b1) begin
                tests_run++; if (out_index !== 3'(exp_k)) begin tests_failed++; $display("FAIL stall_index got %0d exp %0d", out_index, exp_k); end
                tests_run++; if (out_re !== 12'(exp_k * 16)) begin tests_failed++; $display("FAIL stall_re[%0d] got %h exp %h", exp_k, out_re, 12'(exp_k * 16)); end
                tests_run++; if (out_last !== (exp_k == N - 1)) begin tests_failed++; $display("FAIL stall_last[%0d] got %b exp %b", exp_k, out_last, (exp_k == N - 1)); end
                if (stalled) begin
                    tests_run++; if (out_re !== prev_re || out_index !== prev_ix) begin tests_failed++; $display("FAIL stall_hold got %h/%0d exp %h/%0d", out_re, out_index, prev_re, prev_ix); end
                end
                prev_re   = out_re;
                prev_ix   = out_index;
                out_ready = ~out_ready;
                stalled   = ~out_ready;
                if (out_ready) exp_k++;
            end
            @(negedge clk);
        end
        tests_run++; if (exp_k != N) begin tests_failed++; $display("FAIL stall_count got %0d exp %0d", exp_k, N); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_valid_end got %b exp 0", out_valid); end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic saw_enable = 1'b0;
        for (int i = 0; i < 5; i++) push(vec1[i]);
        in_valid = 1'b0;
        tests_run++; if (fft_samples[4] !== vec1[4]) begin tests_failed++; $display("FAIL rmid_loaded got %h exp %h", fft_samples[4], vec1[4]); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (fft_samples[0] !== 12'h000) begin tests_failed++; $display("FAIL rmid_async_clear got %h exp 000", fft_samples[0]); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (fft_enable === 1'b1) saw_enable = 1'b1;
            @(negedge clk);
        end
        tests_run++; if (saw_enable !== 1'b0) begin tests_failed++; $display("FAIL rmid_no_enable got %b exp 0", saw_enable); end
        for (int i = 0; i < N; i++) begin
            tests_run++; if (fft_enable !== 1'b0) begin tests_failed++; $display("FAIL rmid_early_enable[%0d] got %b exp 0", i, fft_enable); end
            push(vec3[i]);
        end
        in_valid = 1'b0;
        tests_run++; if (fft_enable !== 1'b1) begin tests_failed++; $display("FAIL rmid_enable got %b exp 1", fft_enable); end
        for (int i = 0; i < N; i++) begin
            tests_run++; if (fft_samples[i] !== vec3[i]) begin tests_failed++; $display("FAIL rmid_samples[%0d] got %h exp %h", i, fft_samples[i], vec3[i]); end
        end
        wait_out_valid("rmid");
        for (int k = 0; k < N; k++) begin
            tests_run++; if (out_index !== 3'(k) || out_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_bin got idx %0d v %b exp idx %0d v 1", out_index, out_valid, k); end
            @(negedge clk);
        end
        tests_run++; if (dbg_state !== ST_LOAD) begin tests_failed++; $display("FAIL rmid_state_end got %0d exp %0d", dbg_state, ST_LOAD); end
    endtask

`ifdef FFT_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        stub_en = 1'b0;
        for (int i = 0; i < N; i++) push(vec2[i]);
        in_valid = 1'b0;
        tests_run++; if (fft_enable !== 1'b1) begin tests_failed++; $display("FAIL tmo_enable got %b exp 1", fft_enable); end
        for (int c = 1; c < TMO; c++) begin
            @(negedge clk);
            tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL tmo_early_error cycle %0d got %b exp 0", c, error); end
        end
        tests_run++; if (dbg_state !== ST_WAIT) begin tests_failed++; $display("FAIL tmo_state_wait got %0d exp %0d", dbg_state, ST_WAIT); end
        @(negedge clk);
        tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL tmo_error got %b exp 1", error); end
        tests_run++; if (dbg_state !== ST_LOAD) begin tests_failed++; $display("FAIL tmo_state got %0d exp %0d", dbg_state, ST_LOAD); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL tmo_in_ready got %b exp 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL tmo_out_valid got %b exp 0", out_valid); end
        stub_en = 1'b1;
        for (int i = 0; i < N; i++) push(vec1[i]);
        in_valid = 1'b0;
        wait_out_valid("tmo");
        tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL tmo_sticky got %b exp 1", error); end
        tests_run++; if (out_index !== 3'd0) begin tests_failed++; $display("FAIL tmo_next_index got %0d exp 0", out_index); end
        repeat (N) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL tmo_error_cleared got %b exp 0", error); end
    endtask
`else
    task automatic test_no_timeout();
        stub_en = 1'b0;
        for (int i = 0; i < N; i++) push(vec2[i]);
        in_valid = 1'b0;
        repeat (2 * TMO) @(negedge clk);
        tests_run++; if (dbg_state !== ST_WAIT) begin tests_failed++; $display("FAIL notmo_state got %0d exp %0d", dbg_state, ST_WAIT); end
        tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL notmo_error got %b exp 0", error); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL notmo_valid got %b exp 0", out_valid); end
        manual_finish = 1'b1;
        @(negedge clk);
        manual_finish = 1'b0;
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL notmo_valid_after got %b exp 1", out_valid); end
        tests_run++; if (out_re !== 12'h000 || out_index !== 3'd0) begin tests_failed++; $display("FAIL notmo_bin0 got %h/%0d exp 000/0", out_re, out_index); end
        repeat (N) @(negedge clk);
        tests_run++; if (dbg_state !== ST_LOAD) begin tests_failed++; $display("FAIL notmo_state_end got %0d exp %0d", dbg_state, ST_LOAD); end
        stub_en = 1'b1;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_frame();
        test_ignore_finish();
        test_stall();
        test_reset_mid();
`ifdef FFT_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded 200000 time units");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter N_PTS, default 8, meaning points per FFT frame (power of 2, >=2).
REQ-002 SHALL have parameter DW, default 12, meaning sample and bin word width (signed).
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning max cycles from FFT_ENABLE to FFT_FINISH.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 IN_VALID / IN_READY  input / output  1 / 1  time-sample stream handshake.
REQ-007 IN_SAMPLE  input  DW  signed time sample, 5.7 fixed point.
REQ-008 FFT_ENABLE  output  1  one-cycle start strobe to the FFT core.
REQ-009 FFT_SAMPLES  output  N_PTS x DW  unpacked frame driven to the FFT core, index 0 = first accepted sample.
REQ-010 FFT_FINISH  input  1  FFT core done strobe.
REQ-011 FFT_RE / FFT_IM  input  N_PTS x DW each  FFT core bins, 8.4 fixed point.
REQ-012 OUT_VALID / OUT_READY  output / input  1 / 1  frequency-bin stream handshake.
REQ-013 OUT_RE / OUT_IM  output  DW each  current bin.
REQ-014 OUT_INDEX  output  log2(N_PTS)  bin number; OUT_LAST  output  1  high with bin N_PTS-1.
REQ-015 BUSY  output  1  high in any state except LOAD; ERROR  output  1  sticky timeout flag.

Function
REQ-016 SHALL implement FSM LOAD -> START -> WAIT -> UNLOAD -> LOAD.
REQ-017 LOAD: IN_READY=1; each IN_VALID&&IN_READY writes IN_SAMPLE to FFT_SAMPLES[wr_cnt], wr_cnt++; on accepting sample N_PTS-1 go START next cycle.
REQ-018 START: FFT_ENABLE=1 for exactly one cycle, IN_READY=0, FFT_SAMPLES held stable; go WAIT.
REQ-019 WAIT: on FFT_FINISH=1 capture all FFT_RE/FFT_IM into a local bin buffer in that cycle, go UNLOAD; FFT_SAMPLES held stable throughout.
REQ-020 FFT_FINISH outside WAIT SHALL be ignored (no capture, no state change).
REQ-021 UNLOAD: OUT_VALID=1, OUT_RE/OUT_IM/OUT_INDEX from buffer at rd_cnt; rd_cnt++ on OUT_VALID&&OUT_READY; outputs stable while OUT_READY=0.
REQ-022 Handshake of bin N_PTS-1 (OUT_LAST=1) SHALL return to LOAD with wr_cnt=rd_cnt=0; first sample of next frame accepted the following cycle at earliest.
REQ-023 Latency: FFT_ENABLE asserts 1 cycle after last-sample handshake; OUT_VALID asserts 1 cycle after FFT_FINISH.
REQ-024 Counters SHALL wrap only via state transitions; no bin or sample is skipped or repeated.

Reset
REQ-025 RESET=1 SHALL asynchronously force state LOAD, wr_cnt=rd_cnt=0, timeout counter=0, FFT_SAMPLES and bin buffer 0, FFT_ENABLE=0, OUT_VALID=0, OUT_LAST=0, OUT_INDEX=0, OUT_RE=OUT_IM=0, BUSY=0, ERROR=0; IN_READY=1 after release.
REQ-026 RESET mid-frame SHALL discard partial frame and buffered bins; no FFT_ENABLE generated by reset release.

Configuration
REQ-027 Macro FFT_CTRL_TIMEOUT_EN defined: WAIT counts cycles; if count reaches TIMEOUT without FFT_FINISH, set ERROR=1 (sticky until RESET) and return to LOAD with counters cleared, no output produced.
REQ-028 Macro undefined: no timeout counter, WAIT waits indefinitely, ERROR tied 0.

Structure
REQ-029 Shared package fft_pkg SHALL hold DW/N_PTS defaults, sample/bin typedefs and the FSM state enum.
REQ-030 Timeout counter MAY be sub-module fft_watchdog; bin buffer and FSM stay in fft_frame_ctrl.

Verification
REQ-031 Bench SHALL use a behavioural FFT stub asserting FFT_FINISH 3 cycles after FFT_ENABLE, returning bin k = {re=k*16, im=-k*16}.
REQ-032 Feed samples 12'h640,12'hE00,12'h800,12'h270,12'h480,12'h730,12'h880,12'hE80 back-to-back -> FFT_ENABLE single pulse 1 cycle after 8th, FFT_SAMPLES matches order.
REQ-033 OUT_READY=1 continuously -> 8 bins on consecutive cycles, OUT_INDEX 0..7, OUT_LAST only on 7, OUT_RE=k*16.
REQ-034 OUT_READY toggled 1/0 and IN_VALID gaps -> no lost/duplicated bins, outputs stable while stalled.
REQ-035 RESET pulse after 5 samples -> all outputs to reset values, next 8 samples form a clean frame.
REQ-036 With FFT_CTRL_TIMEOUT_EN, stub never finishes -> ERROR=1 exactly TIMEOUT cycles after FFT_ENABLE, state LOAD, IN_READY=1.
